// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the sequential CORDIC rotation engine.
package cordic_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned FRAC  = 16;
    localparam int unsigned ITER  = 16;

    localparam int CORDIC_INV_GAIN = 39797;
    localparam int ANGLE_PI_4      = 51471;
    localparam int ANGLE_MAX       = 114247;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/cordic_rotate_seq_microrot.sv
// One CORDIC micro-rotation: direction taken from the sign of z, shifts are arithmetic.
module cordic_microrot #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 4
) (
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] y_i,
    input  logic signed [WIDTH-1:0] z_i,
    input  logic        [SHW-1:0]   shift_i,
    input  logic signed [WIDTH-1:0] atan_i,
    output logic signed [WIDTH-1:0] x_o,
    output logic signed [WIDTH-1:0] y_o,
    output logic signed [WIDTH-1:0] z_o
);

    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;

    assign x_sh = x_i >>> shift_i;
    assign y_sh = y_i >>> shift_i;

    always_comb begin
        x_o = x_i;
        y_o = y_i;
        z_o = z_i;
        if (!z_i[WIDTH-1]) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end
    end

endmodule

// File: rtl/cordic_rotate_seq.sv
// Iterative CORDIC rotation: one micro-rotation per clock, arctangent supplied by an external table.
module cordic_rotate_seq
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = cordic_pkg::WIDTH,
    parameter int unsigned ITER  = cordic_pkg::ITER,
    parameter int unsigned FRAC  = cordic_pkg::FRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic        [WIDTH-1:0] atan_idx,
    input  logic signed [WIDTH-1:0] atan_val,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    done
);

    localparam int unsigned IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [IW-1:0] LAST = IW'(ITER - 1);

    if (ITER > 16 || ITER == 0 || FRAC >= WIDTH) begin : g_param_check
        $error("cordic_rotate_seq: ITER must be 1..16 and FRAC below WIDTH");
    end

    state_e                  state_q;
    logic [IW-1:0]           iter_q;
    logic signed [WIDTH-1:0] x_q, y_q, z_q;
    logic signed [WIDTH-1:0] x_d, y_d, z_d;
    logic signed [WIDTH-1:0] x_out_q, y_out_q, z_out_q;
    logic                    ready_q;
    logic                    done_q;

    cordic_microrot #(
        .WIDTH (WIDTH),
        .SHW   (IW)
    ) u_microrot (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (iter_q),
        .atan_i  (atan_val),
        .x_o     (x_d),
        .y_o     (y_d),
        .z_o     (z_d)
    );

    // The table answers combinationally, so the index must follow iter_q within the same cycle.
    assign atan_idx = (state_q == RUN) ? WIDTH'(iter_q) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= x_in;
                        y_q     <= y_in;
                        z_q     <= z_in;
                        iter_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    x_q    <= x_d;
                    y_q    <= y_d;
                    z_q    <= z_d;
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == LAST) begin
                        x_out_q <= x_d;
                        y_out_q <= y_d;
                        z_out_q <= z_d;
                        iter_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign x_out = x_out_q;
    assign y_out = y_out_q;
    assign z_out = z_out_q;

endmodule

// File: doc/cordic_rotate_seq.md
Name: cordic_rotate_seq

Overview:
Iterative, one-micro-rotation-per-cycle CORDIC rotation engine. It is the consumer of the arctangent table interface: it drives the table index each cycle and consumes the returned Q16 arctangent. Given a prescaled vector (x, y) and an angle z, it returns the rotated vector. It sits between the angle/vector sources and the sin/cos post-processing logic.

Parameters:
WIDTH, 32, datapath width of x/y/z and of the table index/value ports (two's complement)
ITER, 16, number of micro-rotations; must not exceed table depth (16)
FRAC, 16, fractional bits of angle and vector (Q16; 65536 = 1.0, 51471 = pi/4 rad)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
start  in  1  request; sampled only while ready=1
ready  out  1  high in IDLE only
x_in  in  WIDTH  signed initial x (caller pre-multiplies by 1/K = 39797 Q16)
y_in  in  WIDTH  signed initial y
z_in  in  WIDTH  signed angle, Q16 rad, |z_in| <= 114247 (convergence limit)
atan_idx  out  WIDTH  table index = current iteration number
atan_val  in  WIDTH  atan(2^-atan_idx) in Q16, combinational response to atan_idx (same cycle)
x_out  out  WIDTH  signed rotated x
y_out  out  WIDTH  signed rotated y
z_out  out  WIDTH  signed residual angle
done  out  1  one-cycle pulse; x/y/z_out valid from this cycle onward

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): state IDLE, iter=0, ready=1, done=0, atan_idx=0, x_out=y_out=z_out=0. Reset mid-run aborts the operation. No done is produced for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: at an edge with start=1. x_in/y_in/z_in are loaded into x/y/z working registers and iter is cleared to 0.
- RUN: atan_idx = iter (zero-extended) combinationally; atan_val is used in the same cycle. At each edge:
  - d = +1 if z >= 0, else -1
  - x <= x - d*(y >>> iter)
  - y <= y + d*(x >>> iter)
  - z <= z - d*atan_val
  - Shifts are arithmetic. All sums wrap modulo 2^WIDTH, with no saturation.
  - iter increments on each edge.
- RUN -> DONE: on the edge that performs iteration ITER-1. The same edge registers the final x/y/z into x_out/y_out/z_out.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally at the next edge.
- Latency: start sampled at edge T gives done=1 in the cycle after edge T+ITER. Throughput is one operation per ITER+2 cycles.
- start while not IDLE: ignored, with no queuing. start in the DONE cycle is also ignored.
- atan_idx holds 0 in IDLE and DONE.
- x_out/y_out/z_out hold their values until the next DONE (or reset).
- z_in outside the convergence range: still runs ITER iterations, and the result is undefined numerically but deterministic. No error flag.

Decomposition:
- Package cordic_pkg holds: WIDTH, FRAC, ITER defaults; CORDIC_INV_GAIN = 39797 (Q16); ANGLE_PI_4 = 51471; ANGLE_MAX = 114247; the state enum {IDLE, RUN, DONE}.
- One natural combinational sub-module: cordic_microrot. Inputs x, y, z, shift amount and atan value. Outputs next x, y, z. It is instantiated once and time-multiplexed by the FSM.

Test Plan:
- Reset, then x_in=39797, y_in=0, z_in=0, start -> done exactly ITER cycles after the start edge; x_out=65536±16, y_out=0±16, z_out within ±2 of 0.
- z_in=51471 (pi/4), x_in=39797, y_in=0 -> x_out=46341±16, y_out=46341±16. Monitor atan_idx = 0,1,...,15 on consecutive RUN cycles.
- z_in=102944 (pi/2) -> x_out=0±16, y_out=65536±16.
- z_in=-51471 -> x_out=46341±16, y_out=-46341±16. A second start pulsed mid-RUN is ignored: exactly one done pulse, ready=0 throughout RUN/DONE.
- rst_n=0 for one edge at iteration 7 -> next cycle IDLE, ready=1, outputs 0, atan_idx=0, no done. A new start then completes normally with the pi/4 result.
- Back-to-back: start held high continuously -> operations accepted every ITER+2 cycles; done pulses are one cycle wide and each result matches its own inputs.
